calc_cmd_sequencer: RTL and testbench

Command sequencer and arbiter for the stack calculator core. It turns debounced button edges (operand taken from Switch) and UART command bytes into single calculator commands. The two sources share the core's command port through round-robin arbitration and a valid/ready handshake. It sits between the debouncers/UART receiver and the calculator core in the board-level top.

---
 rtl/calc_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer for the stack calculator: turns button edges and UART
// command bytes into one valid/ready command stream with round-robin arbitration.
package calc_cmd_pkg;
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
    } cmd_t;

    localparam logic [1:0] OP_PUSH_LO = 2'b00;
    localparam logic [1:0] OP_PUSH_HI = 2'b01;
    localparam logic [1:0] OP_EXEC    = 2'b10;

    localparam logic [7:0] CH_LOW  = 8'h4C;
    localparam logic [7:0] CH_HIGH = 8'h48;
    localparam logic [7:0] CH_EXEC = 8'h58;
endpackage

module calc_cmd_sequencer
    import calc_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TO_W       = 26,
    parameter int unsigned TIMEOUT    = 50_000_000
) (
    input  logic                         Clk,
    input  logic                         ResetN,
    input  logic                         BtnPushLow,
    input  logic                         BtnPushHi,
    input  logic                         BtnExecute,
    input  logic [7:0]                   Switch,
    input  logic [7:0]                   RxData,
    input  logic                         RxValid,
    input  logic                         CmdReady,
    output logic                         CmdValid,
    output logic [1:0]                   CmdOp,
    output logic [7:0]                   CmdData,
    output logic                         CmdSrc,
    output logic [$clog2(FIFO_DEPTH):0]  FifoCount,
    input  logic                         ClearFlags,
    output logic                         Overflow,
    output logic                         ParseErr,
    output logic                         BtnDrop
);

    localparam int unsigned        PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned        CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        P_IDLE = 1'b0,
        P_WAIT = 1'b1
    } pstate_t;

    // ------------------------------------------------------------------
    // Button edge detection and pending slots (bit0 low, bit1 high, bit2 exec)
    // ------------------------------------------------------------------
    logic [2:0] btn_in;
    logic [2:0] btn_q;
    logic [2:0] btn_edge;
    logic [2:0] btn_accept;
    logic [2:0] pend_q;
    logic [2:0] pend_pop;
    logic [7:0] lo_data_q;
    logic [7:0] hi_data_q;
    logic       btn_drop_set;

    assign btn_in       = {BtnExecute, BtnPushHi, BtnPushLow};
    assign btn_edge     = btn_in & ~btn_q;
    // A slot being popped this cycle is free again for a new edge.
    assign btn_accept   = btn_edge & (~pend_q | pend_pop);
    assign btn_drop_set = |(btn_edge & ~btn_accept);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            btn_q     <= '0;
            pend_q    <= '0;
            lo_data_q <= '0;
            hi_data_q <= '0;
        end else begin
            btn_q  <= btn_in;
            pend_q <= (pend_q & ~pend_pop) | btn_accept;
            if (btn_accept[0]) lo_data_q <= Switch;
            if (btn_accept[1]) hi_data_q <= Switch;
        end
    end

    // ------------------------------------------------------------------
    // UART parser FSM
    // ------------------------------------------------------------------
    pstate_t         p_state_q;
    pstate_t         p_state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic [1:0]      p_op_q;
    logic [1:0]      p_op_d;
    logic            enq_req;
    cmd_t            enq_cmd;
    logic            perr_set;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            p_state_q <= P_IDLE;
            to_cnt_q  <= '0;
            p_op_q    <= OP_PUSH_LO;
        end else begin
            p_state_q <= p_state_d;
            to_cnt_q  <= to_cnt_d;
            p_op_q    <= p_op_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        to_cnt_d  = to_cnt_q;
        p_op_d    = p_op_q;
        enq_req   = 1'b0;
        enq_cmd   = '0;
        perr_set  = 1'b0;
        case (p_state_q)
            P_IDLE: begin
                if (RxValid) begin
                    case (RxData)
                        CH_LOW: begin
                            p_state_d = P_WAIT;
                            p_op_d    = OP_PUSH_LO;
                            to_cnt_d  = '0;
                        end
                        CH_HIGH: begin
                            p_state_d = P_WAIT;
                            p_op_d    = OP_PUSH_HI;
                            to_cnt_d  = '0;
                        end
                        CH_EXEC: begin
                            enq_req    = 1'b1;
                            enq_cmd.op = OP_EXEC;
                        end
                        default: perr_set = 1'b1;
                    endcase
                end
            end
            P_WAIT: begin
                // A data byte arriving in the last allowed cycle still wins.
                if (RxValid) begin
                    enq_req      = 1'b1;
                    enq_cmd.op   = p_op_q;
                    enq_cmd.data = RxData;
                    p_state_d    = P_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    perr_set  = 1'b1;
                    p_state_d = P_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // UART command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full;
    logic             fifo_pop;
    logic             enq_ok;
    logic             ovf_set;
    cmd_t             fifo_head;

    assign fifo_full = (count_q == DEPTH_C);
    assign enq_ok    = enq_req && (!fifo_full || fifo_pop);
    assign ovf_set   = enq_req && !enq_ok;
    assign fifo_head = fifo_mem[rd_ptr_q];
    assign FifoCount = count_q;

    always_ff @(posedge Clk) begin
        if (enq_ok) fifo_mem[wr_ptr_q] <= enq_cmd;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_ok)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({enq_ok, fifo_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration and output register
    // ------------------------------------------------------------------
    logic       out_load;
    logic       btn_req;
    logic       uart_req;
    logic       take_btn;
    logic       take_uart;
    logic       rr_uart_q;
    logic [2:0] btn_sel;
    cmd_t       btn_cmd;

    always_comb begin
        btn_sel = 3'b000;
        btn_cmd = '0;
        if (pend_q[0]) begin
            btn_sel      = 3'b001;
            btn_cmd.op   = OP_PUSH_LO;
            btn_cmd.data = lo_data_q;
        end else if (pend_q[1]) begin
            btn_sel      = 3'b010;
            btn_cmd.op   = OP_PUSH_HI;
            btn_cmd.data = hi_data_q;
        end else if (pend_q[2]) begin
            btn_sel    = 3'b100;
            btn_cmd.op = OP_EXEC;
        end
    end

    assign out_load  = !CmdValid || CmdReady;
    assign btn_req   = |pend_q;
    assign uart_req  = (count_q != '0);
    assign take_btn  = out_load && btn_req && (!uart_req || !rr_uart_q);
    assign take_uart = out_load && uart_req && !take_btn;
    assign pend_pop  = take_btn ? btn_sel : 3'b000;
    assign fifo_pop  = take_uart;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            CmdValid  <= 1'b0;
            CmdOp     <= OP_PUSH_LO;
            CmdData   <= '0;
            CmdSrc    <= 1'b0;
            rr_uart_q <= 1'b0;
        end else if (out_load) begin
            CmdValid <= take_btn || take_uart;
            if (take_btn) begin
                CmdOp     <= btn_cmd.op;
                CmdData   <= btn_cmd.data;
                CmdSrc    <= 1'b0;
                rr_uart_q <= 1'b1;
            end else if (take_uart) begin
                CmdOp     <= fifo_head.op;
                CmdData   <= fifo_head.data;
                CmdSrc    <= 1'b1;
                rr_uart_q <= 1'b0;
            end
        end
    end

    // Sticky flags: a set event overrides a simultaneous clear.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Overflow <= 1'b0;
            ParseErr <= 1'b0;
            BtnDrop  <= 1'b0;
        end else begin
            Overflow <= ovf_set      || (Overflow && !ClearFlags);
            ParseErr <= perr_set     || (ParseErr && !ClearFlags);
            BtnDrop  <= btn_drop_set || (BtnDrop  && !ClearFlags);
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_calc_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;

    logic       Clk        = 1'b0;
    logic       ResetN     = 1'b1;
    logic       BtnPushLow = 1'b0;
    logic       BtnPushHi  = 1'b0;
    logic       BtnExecute = 1'b0;
    logic [7:0] Switch     = 8'h00;
    logic [7:0] RxData     = 8'h00;
    logic       RxValid    = 1'b0;
    logic       CmdReady   = 1'b0;
    logic       ClearFlags = 1'b0;
    logic       CmdValid;
    logic [1:0] CmdOp;
    logic [7:0] CmdData;
    logic       CmdSrc;
    logic [2:0] FifoCount;
    logic       Overflow;
    logic       ParseErr;
    logic       BtnDrop;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [2:0]  m_prev;
    logic [2:0]  m_pend;
    logic [7:0]  m_pdata [3];
    logic        m_wait;
    logic [1:0]  m_wop;
    int          m_waited;
    logic [9:0]  m_fifo [$];
    logic        m_valid;
    logic [1:0]  m_op;
    logic [7:0]  m_data;
    logic        m_src;
    logic        m_uart_turn;
    logic        m_ovf;
    logic        m_perr;
    logic        m_bdrop;
    logic [10:0] xfers [$];

    calc_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TO_W       (8),
        .TIMEOUT    (TMO)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .BtnPushLow (BtnPushLow),
        .BtnPushHi  (BtnPushHi),
        .BtnExecute (BtnExecute),
        .Switch     (Switch),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .CmdReady   (CmdReady),
        .CmdValid   (CmdValid),
        .CmdOp      (CmdOp),
        .CmdData    (CmdData),
        .CmdSrc     (CmdSrc),
        .FifoCount  (FifoCount),
        .ClearFlags (ClearFlags),
        .Overflow   (Overflow),
        .ParseErr   (ParseErr),
        .BtnDrop    (BtnDrop)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string p);
        check({p, ".valid"}, 32'(CmdValid),  32'(m_valid));
        check({p, ".op"},    32'(CmdOp),     32'(m_op));
        check({p, ".data"},  32'(CmdData),   32'(m_data));
        check({p, ".src"},   32'(CmdSrc),    32'(m_src));
        check({p, ".count"}, 32'(FifoCount), 32'(m_fifo.size()));
        check({p, ".ovf"},   32'(Overflow),  32'(m_ovf));
        check({p, ".perr"},  32'(ParseErr),  32'(m_perr));
        check({p, ".bdrop"}, 32'(BtnDrop),   32'(m_bdrop));
    endtask

    function automatic logic [10:0] xfer(input int i);
        if (i < xfers.size()) return xfers[i];
        return 11'h7FF;
    endfunction

    task automatic model_reset;
        m_prev = '0; m_pend = '0;
        for (int i = 0; i < 3; i++) m_pdata[i] = 8'h00;
        m_wait = 1'b0; m_wop = 2'b00; m_waited = 0;
        m_fifo.delete();
        m_valid = 1'b0; m_op = 2'b00; m_data = 8'h00; m_src = 1'b0; m_uart_turn = 1'b0;
        m_ovf = 1'b0; m_perr = 1'b0; m_bdrop = 1'b0;
    endtask

    // One clock of the specified behaviour, using the inputs seen at this edge.
    task automatic model_step;
        logic [2:0] b_in;
        logic [9:0] ent;
        logic       have_ent, ovf_set, perr_set, drop_set, hb, hu;
        int         popped;
        b_in = {BtnExecute, BtnPushHi, BtnPushLow};
        ent = '0; have_ent = 0; ovf_set = 0; perr_set = 0; drop_set = 0;
        popped = -1;
        if (!m_valid || CmdReady) begin
            hb = (m_pend != 3'b000);
            hu = (m_fifo.size() > 0);
            if (hb && (!hu || !m_uart_turn)) begin
                popped = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                m_pend[popped] = 1'b0;
                m_valid = 1'b1;
                m_op = 2'(popped);
                m_data = (popped == 2) ? 8'h00 : m_pdata[popped];
                m_src = 1'b0;
                m_uart_turn = 1'b1;
            end else if (hu) begin
                {m_op, m_data} = m_fifo.pop_front();
                m_valid = 1'b1;
                m_src = 1'b1;
                m_uart_turn = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (b_in[i] && !m_prev[i]) begin
                if (m_pend[i]) drop_set = 1;
                else begin
                    m_pend[i] = 1'b1;
                    m_pdata[i] = Switch;
                end
            end
        end
        m_prev = b_in;
        if (m_wait) begin
            if (RxValid) begin
                ent = {m_wop, RxData}; have_ent = 1; m_wait = 0;
            end else begin
                m_waited++;
                if (m_waited == int'(TMO)) begin
                    perr_set = 1; m_wait = 0;
                end
            end
        end else if (RxValid) begin
            case (RxData)
                8'h4C: begin m_wait = 1; m_wop = 2'b00; m_waited = 0; end
                8'h48: begin m_wait = 1; m_wop = 2'b01; m_waited = 0; end
                8'h58: begin ent = {2'b10, 8'h00}; have_ent = 1; end
                default: perr_set = 1;
            endcase
        end
        if (have_ent) begin
            if (m_fifo.size() < int'(DEPTH)) m_fifo.push_back(ent);
            else ovf_set = 1;
        end
        m_ovf   = ovf_set  || (m_ovf   && !ClearFlags);
        m_perr  = perr_set || (m_perr  && !ClearFlags);
        m_bdrop = drop_set || (m_bdrop && !ClearFlags);
        if (popped >= 0) m_pdata[popped] = m_pdata[popped];
    endtask

    task automatic tick;
        @(posedge Clk);
        if (CmdValid && CmdReady) xfers.push_back({CmdOp, CmdData, CmdSrc});
        model_step();
        #1;
        check_all("cyc");
    endtask

    task automatic send(input logic [7:0] b);
        RxData = b;
        RxValid = 1'b1;
        tick();
        RxValid = 1'b0;
    endtask

    task automatic do_reset;
        ResetN = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 32'(CmdValid), 32'h0);
        check_all("rst");
        @(posedge Clk);
        #1;
        check_all("rst_hold");
        ResetN = 1'b1;
    endtask

    initial begin
        do_reset();

        // Button push-low: one command per edge, two-cycle latency
        xfers.delete();
        Switch = 8'h5A; CmdReady = 1'b1;
        BtnPushLow = 1'b1;
        tick(); check("s1_lat1", 32'(CmdValid), 32'h0);
        tick(); check("s1_lat2", 32'(CmdValid), 32'h1);
        tick();
        BtnPushLow = 1'b0; repeat (3) tick();
        check("s1_count", 32'(xfers.size()), 32'd1);
        check("s1_cmd",   32'(xfer(0)), 32'({2'b00, 8'h5A, 1'b0}));
        Switch = 8'h33; BtnPushLow = 1'b1; repeat (3) tick();
        BtnPushLow = 1'b0; tick();
        check("s1_count2", 32'(xfers.size()), 32'd2);
        check("s1_cmd2",   32'(xfer(1)), 32'({2'b00, 8'h33, 1'b0}));

        // UART L,37 then X
        xfers.delete();
        send(8'h4C); send(8'h37); send(8'h58); repeat (4) tick();
        check("s2_cmd0",  32'(xfer(0)), 32'({2'b00, 8'h37, 1'b1}));
        check("s2_cmd1",  32'(xfer(1)), 32'({2'b10, 8'h00, 1'b1}));
        check("s2_count", 32'(FifoCount), 32'd0);
        check("s2_perr",  32'(ParseErr), 32'd0);

        // Held output with backpressure, then round-robin to UART
        xfers.delete();
        CmdReady = 1'b0; Switch = 8'h12; BtnPushHi = 1'b1; tick();
        BtnPushHi = 1'b0;
        send(8'h48); send(8'hA5); repeat (3) tick();
        check("s3_valid", 32'(CmdValid), 32'h1);
        check("s3_hold",  32'({CmdOp, CmdData, CmdSrc}), 32'({2'b01, 8'h12, 1'b0}));
        CmdReady = 1'b1; repeat (3) tick();
        check("s3_cmd0", 32'(xfer(0)), 32'({2'b01, 8'h12, 1'b0}));
        check("s3_cmd1", 32'(xfer(1)), 32'({2'b01, 8'hA5, 1'b1}));

        // FIFO overflow with the output register occupied
        CmdReady = 1'b0; BtnExecute = 1'b1; tick();
        BtnExecute = 1'b0; repeat (2) tick();
        check("s4_exec_op", 32'(CmdOp), 32'h2);
        repeat (5) send(8'h58);
        tick();
        check("s4_full", 32'(FifoCount), 32'd4);
        check("s4_ovf",  32'(Overflow), 32'd1);
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        check("s4_clr", 32'(Overflow), 32'd0);
        xfers.delete();
        CmdReady = 1'b1; repeat (8) tick();
        check("s4_drain", 32'(FifoCount), 32'd0);
        check("s4_n",     32'(xfers.size()), 32'd5);

        // Parser timeout boundary
        xfers.delete();
        send(8'h4C); repeat (7) tick();
        check("s5_pre",  32'(ParseErr), 32'd0);
        tick();
        check("s5_to",   32'(ParseErr), 32'd1);
        check("s5_none", 32'(xfers.size()), 32'd0);
        send(8'h58); repeat (3) tick();
        check("s5_exec", 32'(xfer(0)), 32'({2'b10, 8'h00, 1'b1}));
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        check("s5_clr", 32'(ParseErr), 32'd0);

        // Bad byte, then reset while a command is pending
        send(8'h41);
        check("s6_perr", 32'(ParseErr), 32'd1);
        CmdReady = 1'b0; Switch = 8'h77; BtnPushLow = 1'b1; tick();
        BtnPushLow = 1'b0;
        send(8'h58); send(8'h58); tick();
        check("s6_valid", 32'(CmdValid), 32'h1);
        do_reset();
        tick();
        check("s6_fifo",  32'(FifoCount), 32'd0);
        check("s6_valid0", 32'(CmdValid), 32'd0);
        check("s6_perr0", 32'(ParseErr), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) BtnPushLow = ~BtnPushLow;
            if ($urandom_range(3) == 0) BtnPushHi  = ~BtnPushHi;
            if ($urandom_range(3) == 0) BtnExecute = ~BtnExecute;
            Switch  = 8'($urandom);
            RxValid = ($urandom_range(c < 1500 ? 2 : 11) == 0);
            case ($urandom_range(3))
                0:       RxData = 8'h4C;
                1:       RxData = 8'h48;
                2:       RxData = 8'h58;
                default: RxData = 8'($urandom);
            endcase
            CmdReady   = ($urandom_range(9) < 7);
            ClearFlags = ($urandom_range(15) == 0);
            if ($urandom_range(499) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
